i2s_sample_tx: RTL
==================

Name: i2s_sample_tx

Overview:
Downstream output stage after the gain stage. Accepts gain-modified 32-bit signed PCM samples with a valid pulse and buffers them in a small FIFO. Serialises each sample as a mono-duplicated stereo I2S frame toward the DAC/codec. Generates BCLK and LRCLK internally from CLK.

Parameters:
AUDIO_W, 24, bits transmitted per slot (MSBs of the 32-bit sample); legal range 8..31
BCLK_DIV, 4, CLK cycles per BCLK half-period; BCLK period = 2*BCLK_DIV CLK cycles; legal range >= 2
FIFO_DEPTH, 8, sample FIFO entries; must be a power of 2

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
sample_in  in  32  signed two's-complement PCM sample from gain stage
sample_valid  in  1  one-cycle write strobe for sample_in
sample_ready  out  1  high when FIFO not full
tx_enable  in  1  level; high = serialiser running
clear_flags  in  1  one-cycle pulse; clears sticky flags
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left slot, 1 = right slot
i2s_sdata  out  1  serial data, MSB first
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
underrun  out  1  sticky: frame started with FIFO empty while enabled
overflow  out  1  sticky: sample_valid while FIFO full

Behaviour:
- RESET (sync, dominates all other inputs): FIFO empty, fifo_level=0, sample_ready=1, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0, overflow=0, divider=0, bit counter=63, frame word=0.
- Write: on sample_valid with FIFO not full (registered state at that edge), store converted sample (top AUDIO_W bits, sample_in[31:32-AUDIO_W]). Visible in fifo_level next cycle.
- Full and sample_valid: sample dropped, overflow<=1.
- Divider: runs only while tx_enable=1. Counts 0..BCLK_DIV-1. At terminal count it toggles i2s_bclk and wraps.
- Falling-edge event: the cycle where the divider is at terminal count and i2s_bclk=1. On that cycle the bit counter advances mod 64, and i2s_lrclk and i2s_sdata update.
- Frame: bit counter 0..31 gives lrclk=0; 32..63 gives lrclk=1.
- Slot bit s = counter mod 32. sdata = word[AUDIO_W-s] for s in 1..AUDIO_W, else 0. This gives the standard I2S one-BCLK delay after the LRCLK edge.
- Pop: on the falling-edge event where the counter wraps 63->0.
  - FIFO non-empty: pop head into frame word; the same word is sent in the left and right slots.
  - FIFO empty: frame word<=0 and underrun<=1.
- Simultaneous push and pop: both honoured; level unchanged. If the FIFO is empty at that edge, the pop sees empty (underrun, zeros sent) and the push is stored.
- Full plus simultaneous pop and push: push rejected because sample_ready was 0 at that edge.
- tx_enable deasserted (any time, including mid-frame), next cycle:
  - bclk, lrclk and sdata = 0; divider = 0; bit counter = 63.
  - The in-flight frame word is discarded.
  - FIFO contents and writes are unaffected.
- Re-enable: first bclk rise after BCLK_DIV cycles. First falling edge after 2*BCLK_DIV cycles wraps the counter to 0 and pops.
- clear_flags: clears underrun and overflow. A same-cycle set event wins (flag stays 1).
- Frame length = 128*BCLK_DIV CLK cycles (512 at default).

Optional Feature:
- Macro: I2S_TX_ROUND_EN.
- Defined: conversion at FIFO write rounds half-up. Add 2^(31-AUDIO_W) to sample_in, then take the top AUDIO_W bits. Positive overflow saturates to 0x7F..F (AUDIO_W bits).
- Undefined: plain truncation to the top AUDIO_W bits. No adder is present.

Test Plan:
- Reset check: RESET for 2 cycles mid-traffic -> all outputs 0, fifo_level=0, sample_ready=1, flags 0, FIFO empty afterward.
- Single sample: push 0x12345600, raise tx_enable.
  - First pop at cycle 8 after enable; fifo_level 1->0.
  - Left slot bits 1..24 = 0x123456 MSB first; right slot identical; bits 0 and 25..31 of each slot = 0.
  - BCLK period 8 cycles.
- Underrun: enable with FIFO empty -> sdata constant 0, underrun=1 at first wrap. clear_flags -> 0, then re-set at the next wrap.
- Overflow: tx_enable=0, push 8 samples, then a 9th 0xDEADBEEF -> dropped, overflow=1, fifo_level=8, sample_ready=0. Enable -> the 8 samples are sent in order, none equal to 0xDEADBE.
- Mid-frame disable: drop tx_enable at bit 40 -> next cycle bclk, lrclk and sdata = 0. Re-enable -> the next queued sample is sent; the interrupted one is not resent.
- Rounding: 0x00000080 -> slot value 0x000001 with I2S_TX_ROUND_EN, 0x000000 without. 0x7FFFFF80 -> 0x7FFFFF in both builds (saturated with the macro).

Source files
------------

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx
// Output stage after the gain block. It queues 32-bit signed PCM samples in a
// small FIFO and sends each sample as a stereo I2S frame. The same word goes
// out in the left and the right slot. BCLK and LRCLK are derived from CLK.
//
// Ports
//   CLK, RESET     system clock; synchronous active-high reset
//   sample_in      32-bit signed PCM sample
//   sample_valid   one-cycle write strobe
//   sample_ready   FIFO not full
//   tx_enable      level; serialiser runs while high
//   clear_flags    one-cycle pulse; clears underrun/overflow
//   i2s_bclk       bit clock, period 2*BCLK_DIV CLK cycles
//   i2s_lrclk      word select (0 = left, 1 = right)
//   i2s_sdata      serial data, MSB first, one BCLK after the LRCLK edge
//   fifo_level     FIFO entry count
//   underrun       sticky: frame started with the FIFO empty
//   overflow       sticky: write attempted while the FIFO was full
//
// Build option
//   I2S_TX_ROUND_EN  when defined, samples are rounded half-up (with positive
//                    saturation) instead of truncated when written.
//
// Serialiser states (bit counter r_bit_cnt)
//   state       | meaning
//   disabled    | tx_enable low: clocks/data 0, divider 0, counter 63
//   0..31       | left slot, LRCLK 0
//   32..63      | right slot, LRCLK 1
//   63 -> 0     | frame boundary: pop next word or flag underrun

module i2s_sample_tx #(
   parameter int AUDIO_W    = 24,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [31:0]                   sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   input  logic                          tx_enable,
   input  logic                          clear_flags,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = $clog2(BCLK_DIV);
   localparam logic [DW-1:0] DIV_TC  = DW'(BCLK_DIV - 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [5:0]    AW6     = 6'(AUDIO_W);

   logic [AUDIO_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [LW-1:0]      r_count;
   logic [DW-1:0]      r_div;
   logic               r_bclk;
   logic               r_lrclk;
   logic               r_sdata;
   logic [5:0]         r_bit_cnt;
   logic [AUDIO_W-1:0] r_word;
   logic               r_underrun;
   logic               r_overflow;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_fall;
   logic               w_wrap;
   logic               w_pop;
   logic [5:0]         w_next_cnt;
   logic [5:0]         w_slot;
   logic               w_in_slot;
   logic [AUDIO_W-1:0] w_shift;
   logic [AUDIO_W-1:0] w_conv;
   logic               w_unused;

`ifdef I2S_TX_ROUND_EN
   localparam logic [32:0] ROUND_INC = 33'd1 << (31 - AUDIO_W);
   logic [32:0] w_sum;

   // Sign-extended add; only positive overflow is possible since the
   // increment is positive, detected as a change of the sign bit.
   assign w_sum    = {sample_in[31], sample_in} + ROUND_INC;
   assign w_conv   = (w_sum[32] != w_sum[31]) ? {1'b0, {(AUDIO_W-1){1'b1}}}
                                              : w_sum[31:32-AUDIO_W];
   assign w_unused = ^{w_sum[31-AUDIO_W:0], w_shift[AUDIO_W-1:1]};
`else
   assign w_conv   = sample_in[31:32-AUDIO_W];
   assign w_unused = ^{sample_in[31-AUDIO_W:0], w_shift[AUDIO_W-1:1]};
`endif

   assign w_full   = (r_count == DEPTH_L);
   assign w_empty  = (r_count == '0);
   assign w_push   = sample_valid && !w_full;
   assign w_fall   = tx_enable && (r_div == DIV_TC) && r_bclk;
   assign w_wrap   = w_fall && (r_bit_cnt == 6'd63);
   assign w_pop    = w_wrap && !w_empty;

   // Data for the bit that starts at this falling edge. Slot bit 0 carries
   // nothing, which produces the one-BCLK I2S delay after the LRCLK edge.
   assign w_next_cnt = r_bit_cnt + 6'd1;
   assign w_slot     = {1'b0, w_next_cnt[4:0]};
   assign w_in_slot  = (w_slot != 6'd0) && (w_slot <= AW6);
   assign w_shift    = r_word >> (AW6 - w_slot);

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= w_conv;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_div      <= '0;
         r_bclk     <= 1'b0;
         r_lrclk    <= 1'b0;
         r_sdata    <= 1'b0;
         r_bit_cnt  <= 6'd63;
         r_word     <= '0;
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase

         if (sample_valid && w_full) r_overflow <= 1'b1;
         else if (clear_flags)       r_overflow <= 1'b0;

         if (w_wrap && w_empty)      r_underrun <= 1'b1;
         else if (clear_flags)       r_underrun <= 1'b0;

         if (!tx_enable) begin
            r_div     <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
            r_bit_cnt <= 6'd63;
            r_word    <= '0;
         end else if (r_div == DIV_TC) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
            if (r_bclk) begin
               r_bit_cnt <= w_next_cnt;
               r_lrclk   <= w_next_cnt[5];
               r_sdata   <= w_in_slot && w_shift[0];
               if (w_wrap) r_word <= w_empty ? '0 : r_mem[r_rd_ptr];
            end
         end else begin
            r_div <= r_div + DW'(1);
         end
      end
   end

   assign sample_ready = !w_full;
   assign fifo_level   = r_count;
   assign i2s_bclk     = r_bclk;
   assign i2s_lrclk    = r_lrclk;
   assign i2s_sdata    = r_sdata;
   assign underrun     = r_underrun;
   assign overflow     = r_overflow;

endmodule
